// File: rtl/mul_seq_pkg.sv
// Shared types and defaults for the repeated-addition multiplier job sequencer.
package mul_seq_pkg;

    typedef enum logic [2:0] {
        CLR,
        IDLE,
        LOAD_A,
        LOAD_B,
        RUN,
        RESP
    } seq_state_t;

    localparam int DEF_CLR_CYCLES = 2;

endpackage

// File: rtl/mul_seq_watchdog.sv
// Run-length watchdog for mul_job_sequencer; only built when MUL_SEQ_TIMEOUT_EN is defined.
`ifdef MUL_SEQ_TIMEOUT_EN
module mul_seq_watchdog #(
    parameter int TIMEOUT = 70000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != CW'(TIMEOUT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // High on the edge that takes the count to TIMEOUT, so the FSM leaves on that same edge.
    assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/mul_job_sequencer.sv
// Initiator-side job sequencer for the repeated-addition multiplier.
// Define MUL_SEQ_TIMEOUT_EN to build in the watchdog that turns a hung run into an error result.
module mul_job_sequencer
    import mul_seq_pkg::*;
#(
    parameter int W          = 16,
    parameter int TIMEOUT    = 70000,
    parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [W-1:0] job_a,
    input  logic [W-1:0] job_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_p,
    output logic         res_err,
    output logic         mul_start,
    output logic [W-1:0] mul_data,
    output logic         mul_clr,
    input  logic         mul_lda,
    input  logic         mul_ldb,
    input  logic         mul_done,
    input  logic [W-1:0] mul_p
);

    localparam int CNT_W = $clog2(CLR_CYCLES + 1);

    seq_state_t     state, state_n;
    logic [CNT_W-1:0] clr_cnt;
    logic [W-1:0]   a_q, b_q, res_p_q;
    logic           expired;
    logic           job_xfer, zero_job, in_run_phase, timeout_hit;

    assign job_xfer     = (state == IDLE) && job_valid;
    assign zero_job     = (job_a == '0) || (job_b == '0);
    assign in_run_phase = state inside {LOAD_A, LOAD_B, RUN};
    // mul_done beats a timeout landing on the same edge.
    assign timeout_hit  = expired && in_run_phase && !((state == RUN) && mul_done);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLR;
            clr_cnt <= '0;
        end else begin
            state   <= state_n;
            clr_cnt <= (state == CLR && state_n == CLR) ? clr_cnt + 1'b1 : '0;
        end
    end

    // NOTE: state_n gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_n = state;
        case (state)
            CLR:    if (clr_cnt == CNT_W'(CLR_CYCLES - 1)) state_n = IDLE;
            IDLE:   if (job_valid) state_n = zero_job ? RESP : LOAD_A;
            LOAD_A: if (expired) state_n = RESP;
                    else if (mul_lda) state_n = LOAD_B;
            LOAD_B: if (expired) state_n = RESP;
                    else if (mul_ldb) state_n = RUN;
            RUN:    if (mul_done || expired) state_n = RESP;
            RESP:   if (res_ready) state_n = CLR;
            default: state_n = CLR;
        endcase
    end

    always_comb begin
        mul_clr   = 1'b0;
        job_ready = 1'b0;
        res_valid = 1'b0;
        mul_start = 1'b0;
        mul_data  = '0;
        case (state)
            CLR:    mul_clr   = 1'b1;
            IDLE:   job_ready = 1'b1;
            LOAD_A: begin
                mul_start = 1'b1;
                mul_data  = a_q;
            end
            LOAD_B: mul_data  = b_q;
            RUN:    mul_data  = b_q;
            RESP:   res_valid = 1'b1;
            default: mul_clr  = 1'b1;
        endcase
    end

    // NOTE: operand and result registers are reset so res_p and mul_data read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_p_q <= '0;
        end else if (job_xfer) begin
            a_q     <= job_a;
            b_q     <= job_b;
            res_p_q <= '0;
        end else if ((state == RUN) && mul_done) begin
            res_p_q <= mul_p;
        end else if (timeout_hit) begin
            res_p_q <= '0;
        end
    end

    assign res_p = res_p_q;

`ifdef MUL_SEQ_TIMEOUT_EN
    logic res_err_q;

    mul_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (job_xfer && !zero_job),
        .enable  (in_run_phase),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err_q <= 1'b0;
        end else if (job_xfer || ((state == RUN) && mul_done)) begin
            res_err_q <= 1'b0;
        end else if (timeout_hit) begin
            res_err_q <= 1'b1;
        end
    end

    assign res_err = res_err_q;
`else
    logic unused_timeout;

    // Without the watchdog a run waits for mul_done forever.
    assign expired        = 1'b0;
    assign res_err        = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

endmodule

// File: doc/mul_job_sequencer.md
# mul_job_sequencer

Initiator-side sequencer for the repeated-addition multiplier (controller + datapath pair). Accepts operand jobs over a valid/ready port and drives `mul_start` and the shared operand bus `mul_data` in step with the controller's `LdA`/`LdB` strobes. It waits for `done`, returns the product over a valid/ready result port, then clears the multiplier for the next job. Zero operands are short-circuited, and an optional watchdog bounds a hung run.

## Interface
- `W`, 16: operand and product width; product is modulo 2^W.
- `TIMEOUT`, 70000: maximum cycles from job start to `mul_done`. Must be ≥ 2^W+8.
- `CLR_CYCLES`, 2: cycles `mul_clr` is held after each job and after reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `job_valid` in 1: job offered.
- `job_ready` out 1: sequencer can accept a job.
- `job_a`, `job_b` in W: operands.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumer ready.
- `res_p` out W: product.
- `res_err` out 1: result is a timeout, not a product.
- `mul_start` out 1: start to the multiplier controller.
- `mul_data` out W: operand bus to the datapath.
- `mul_clr` out 1: multiplier clear; the controller returns to s0 while it is high.
- `mul_lda`, `mul_ldb` in 1: controller load strobes.
- `mul_done` in 1: controller done.
- `mul_p` in W: datapath product register.

## Operation
- States: CLR, IDLE, LOAD_A, LOAD_B, RUN, RESP. State is registered; all outputs are decoded from state and registers.
- A handshake transfer occurs on a rising edge with valid and ready both high.
- CLR: `mul_clr`=1. Count `CLR_CYCLES` edges, then go to IDLE.
- IDLE: `job_ready`=1. On transfer, capture a and b.
  - If a==0 or b==0: `res_p`=0, `res_err`=0, go to RESP. The multiplier is never engaged and CLR is still run afterwards.
  - Otherwise go to LOAD_A.
- LOAD_A: `mul_start`=1, `mul_data`=a. Go to LOAD_B on the first edge sampling `mul_lda`=1.
- LOAD_B: `mul_start`=0, `mul_data`=b. Go to RUN on the first edge sampling `mul_ldb`=1.
- RUN: `mul_data`=b. On `mul_done`=1, capture `mul_p` into `res_p`, set `res_err`=0, go to RESP.
- `mul_done` is honoured only in RUN. In LOAD_A and LOAD_B it is ignored.
- RESP: `res_valid`=1. `res_p` and `res_err` are held stable until the transfer, then go to CLR.
- `job_ready`=0 in every state except IDLE. No job is accepted while a result is pending.

## Timing
- Reset values while `rst_n`=0:
  - state=CLR, CLR counter=0.
  - `mul_clr`=1; `job_ready`=0; `res_valid`=0; `res_p`=0; `res_err`=0; `mul_start`=0; `mul_data`=0.
- Reset mid-operation aborts immediately: the job is discarded, `res_valid` drops, `mul_clr` rises.
- After `rst_n` deasserts, `job_ready` rises after exactly `CLR_CYCLES` edges.
- Job accepted at edge n:
  - `mul_start` is high in cycle n+1.
  - Zero short-circuit: `res_valid` is high in cycle n+1.
- Result accepted at edge m: `mul_clr` is high in cycles m+1 … m+`CLR_CYCLES`, and `job_ready` is high at m+`CLR_CYCLES`+1.
- Strobes are sampled on the rising edge; combinational paths from inputs to outputs are forbidden.

## Configuration
- Macro `MUL_SEQ_TIMEOUT_EN` defined:
  - The watchdog counts edges in LOAD_A, LOAD_B and RUN, and is cleared on entering LOAD_A.
  - On reaching `TIMEOUT` (LOAD_A entered at edge k; counter reaches `TIMEOUT` at edge k+`TIMEOUT`): go to RESP with `res_err`=1, `res_p`=0.
  - `mul_done` and timeout on the same edge: `mul_done` wins.
- Macro undefined: no counter. `res_err` is tied to 0 and RUN waits indefinitely.

## Structure
- Shared package `mul_seq_pkg`: state enum (`CLR`, `IDLE`, `LOAD_A`, `LOAD_B`, `RUN`, `RESP`) and the default `CLR_CYCLES` constant.
- One sub-module, `mul_seq_watchdog`, compiled only under the macro.
  - Ports: clear, enable, expired.
  - Counter width $clog2(`TIMEOUT`+1).

## Test plan
- a=3, b=4; multiplier model asserts `mul_done` with `mul_p`=12 → `res_p`=12, `res_err`=0, then `mul_clr` high for exactly 2 cycles and `job_ready` back high.
- a=0, b=9 → `res_valid` high one cycle after accept, `res_p`=0, `mul_start` never asserted.
- a=5, b=7 with `res_ready` held low for 10 cycles → `res_valid`=1 and `res_p`=35 stable throughout, `job_ready`=0; a second `job_valid` is not accepted.
- Macro on, `TIMEOUT`=64, model never raises `mul_done` → `res_valid` with `res_err`=1 and `res_p`=0 at edge k+64 after LOAD_A entry at edge k.
- `rst_n` pulsed low during RUN → `mul_clr`=1 and `res_valid`=0 immediately; `job_ready` rises 2 edges after release.
- Back-to-back jobs (255,255) then (6,7) with `res_ready`=1 → results 65025 then 42, in order, with a CLR phase between them.
